array_mult_sequencer: RTL and testbench

- Multi-cycle unsigned multiplier controller. Computes a (4*N)x(4*N)-bit product by time-sharing one array_multiplier_4bit instance, one nibble-pair per cycle, and shift-accumulating the partial products.
- Sits between a valid/ready operand producer and a valid/ready result consumer.
- Reuses the existing combinational 4x4 array multiplier as its only multiply resource.

---
 rtl/array_mult_sequencer.sv | 140 ++++++++++++++
 tb/tb_array_mult_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/array_mult_sequencer.sv
// array_mult_sequencer: unsigned (4*N)x(4*N) multiplier built around a single
// combinational 4x4 array multiplier, one nibble pair per cycle, shift-accumulated.
// Ports: clk/rst (async active-high); in_valid/in_ready + a/b operand handshake;
//        out_valid/out_ready + p product handshake; busy = operation in flight.
// Latency: N*N cycles from acceptance to out_valid; DONE holds under back-pressure.

// array_multiplier_4bit: combinational 4x4 unsigned array multiplier.
// Ports: a, b 4-bit operands; p 8-bit product.
module array_multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  // Sum of the four AND-gated partial-product rows.
  always_comb begin
    p = 8'd0;
    for (int k = 0; k < 4; k++) begin
      p = p + ({4'b0000, a & {4{b[k]}}} << k);
    end
  end
endmodule

module array_mult_sequencer #(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*N-1:0]   a,
  input  logic [4*N-1:0]   b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*N-1:0]   p,
  output logic             busy
);
  localparam int W  = 4 * N;
  localparam int PW = 8 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   j_q, j_d;

  logic [3:0]      a_nib, b_nib;
  logic [7:0]      mul_p;
  logic [SW-1:0]   shamt;
  logic [PW-1:0]   pp_sh;
  logic [PW-1:0]   acc_sum;

  assign a_nib = a_q[i_q*4 +: 4];
  assign b_nib = b_q[j_q*4 +: 4];

  array_multiplier_4bit u_mul (
    .a (a_nib),
    .b (b_nib),
    .p (mul_p)
  );

  // Nibble pair (i,j) carries weight 2^(4*(i+j)); max shift is 8*(N-1) < PW.
  assign shamt   = (SW'(i_q) + SW'(j_q)) << 2;
  assign pp_sh   = PW'(mul_p) << shamt;
  assign acc_sum = acc_q + pp_sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_sum;
        if (i_q == IW'(N - 1)) begin
          i_d = '0;
          if (j_q == IW'(N - 1)) begin
            // Last pair: publish the final sum directly, not the stale acc_q.
            j_d     = '0;
            p_d     = acc_sum;
            state_d = DONE;
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;
endmodule

// File: tb/tb_array_mult_sequencer.sv
module tb_array_mult_sequencer;
  localparam int N   = 2;
  localparam int LAT = N * N;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4*N-1:0]  a;
  logic [4*N-1:0]  b;
  logic            out_valid;
  logic            out_ready;
  logic [8*N-1:0]  p;
  logic            busy;

  int total = 0;
  int bad   = 0;

  array_mult_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: plain integer multiply of the operands.
  function automatic logic [31:0] model(input logic [4*N-1:0] x, input logic [4*N-1:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Counts edges after acceptance until out_valid is seen (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction: accept, scramble inputs, wait, optionally stall, handshake.
  task automatic run_op(input string tag, input logic [4*N-1:0] av,
                        input logic [4*N-1:0] bv, input int stall);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    wait_result(lat);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_p"}, 32'(p), model(av, bv));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_hold"}, {15'd0, in_ready, p}, {15'd0, 1'b0, 16'(model(av, bv))});
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_hs"}, {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int got;
    int last_cyc;
    int idx;
    logic acc;
    logic [4*N-1:0] pa [4];
    logic [4*N-1:0] pb [4];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    #3 rst = 1'b0;

    // Directed products.
    run_op("zero", 8'h00, 8'h00, 0);
    run_op("p03x05", 8'h03, 8'h05, 0);
    run_op("pFFxFF", 8'hFF, 8'hFF, 0);
    run_op("pA7x3C", 8'hA7, 8'h3C, 0);
    check("p_kept", 32'(p), 32'h2724);

    // Back-pressure with a competing operand pair.
    in_valid  = 1'b1;
    a         = 8'h12;
    b         = 8'h34;
    out_ready = 1'b0;
    tick();
    a = 8'h55;
    b = 8'h66;
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'(LAT));
    for (int s = 0; s < 5; s++) begin
      check("bp_hold", {14'd0, out_valid, in_ready, p}, {14'd0, 1'b1, 1'b0, 16'h03A8});
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_hs", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_pending_acc", 32'(busy), 32'd1);
    wait_result(lat);
    check("bp_pending_lat", 32'(lat), 32'(LAT));
    check("bp_pending_p", 32'(p), model(8'h55, 8'h66));
    tick();

    // Operand change after acceptance has no effect.
    in_valid = 1'b1;
    a        = 8'h0F;
    b        = 8'h0F;
    tick();
    in_valid = 1'b0;
    a        = 8'hFF;
    wait_result(lat);
    check("opchg_p", 32'(p), 32'h00E1);
    tick();

    // Asynchronous reset during the second accumulate cycle.
    in_valid = 1'b1;
    a        = 8'h77;
    b        = 8'h99;
    tick();
    in_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_now", {29'd0, out_valid, busy, in_ready}, 32'd1);
    check("arst_p", 32'(p), 32'd0);
    tick();
    #3 rst = 1'b0;
    run_op("post_rst", 8'h10, 8'h10, 0);
    tick();
    check("no_ghost", 32'(out_valid), 32'd0);

    // Back-to-back stream with in_valid and out_ready held high.
    for (int k = 0; k < 4; k++) begin
      pa[k] = 8'($urandom);
      pb[k] = 8'($urandom);
    end
    idx       = 0;
    got       = 0;
    last_cyc  = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = pa[0];
    b         = pb[0];
    for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
      if (out_valid) begin
        check("b2b_p", 32'(p), model(pa[got], pb[got]));
        if (got > 0) check("b2b_gap", 32'(cyc - last_cyc), 32'(LAT + 2));
        last_cyc = cyc;
        got++;
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) begin
          a = pa[idx];
          b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(got), 32'd4);
    for (int s = 0; s < 8; s++) begin
      tick();
      check("b2b_extra", 32'(out_valid), 32'd0);
    end

    // Random operands with random consumer stalls.
    for (int k = 0; k < 12; k++) begin
      run_op("rand", 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
